// File: rtl/decode_execute_pkg.sv
// Shared opcodes and instruction field layout for decode_execute_pipe.
// The instruction word is {sel, rd_addr, rs_addr, rt_addr}, with rt_addr in the low bits.
package decode_execute_pkg;

   typedef enum logic [2:0] {
      OP_SUB = 3'b000,
      OP_ADD = 3'b001,
      OP_OR  = 3'b010,
      OP_AND = 3'b011,
      OP_ASR = 3'b100,
      OP_ROL = 3'b101,
      OP_LT  = 3'b110,
      OP_EQ  = 3'b111
   } op_e;

   function automatic int rt_lsb(input int aw);
      return 0;
   endfunction

   function automatic int rs_lsb(input int aw);
      return aw;
   endfunction

   function automatic int rd_lsb(input int aw);
      return 2 * aw;
   endfunction

   function automatic int sel_lsb(input int aw);
      return 3 * aw;
   endfunction

endpackage

// File: rtl/decode_execute_pipe_alu_core.sv
// Combinational ALU with eight operations on WIDTH-bit data.
// The carry output is driven only by ADD (carry) and SUB (no-borrow).
module alu_core
   import decode_execute_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] ext;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ext    = '0;
      case (sel)
         OP_SUB: begin
            ext    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            result = ext[WIDTH-1:0];
            carry  = ext[WIDTH];
         end
         OP_ADD: begin
            ext    = {1'b0, a} + {1'b0, b};
            result = ext[WIDTH-1:0];
            carry  = ext[WIDTH];
         end
         OP_OR:  result = a | b;
         OP_AND: result = a & b;
         OP_ASR: result = {b[WIDTH-1], b[WIDTH-1:1]};
         OP_ROL: result = {a[WIDTH-2:0], a[WIDTH-1]};
         OP_LT:  result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/decode_execute_pipe.sv
// Two-stage decode/execute pipeline: the register file feeds S1, which feeds the ALU,
// which feeds the S2 output registers, with writeback and valid/ready handshakes.
module decode_execute_pipe
   import decode_execute_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int NREG  = 4,
   localparam int AW    = $clog2(NREG),
   localparam int IW    = 3 + 3 * AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IW-1:0]    in_instr,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [WIDTH-1:0] cfg_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    out_rd,
   output logic             out_carry,
   output logic             out_zero
);

   logic [WIDTH-1:0] regfile [NREG];

   logic             s1_valid;
   logic [2:0]       s1_sel;
   logic [AW-1:0]    s1_rd;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             advance;
   logic             accept;
   logic             transfer;

   logic [2:0]       dec_sel;
   logic [AW-1:0]    dec_rd;
   logic [AW-1:0]    dec_rs;
   logic [AW-1:0]    dec_rt;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;

   assign dec_sel = in_instr[sel_lsb(AW) +: 3];
   assign dec_rd  = in_instr[rd_lsb(AW) +: AW];
   assign dec_rs  = in_instr[rs_lsb(AW) +: AW];
   assign dec_rt  = in_instr[rt_lsb(AW) +: AW];

   assign advance  = !out_valid || out_ready;
   assign in_ready = !s1_valid || advance;
   assign accept   = in_valid && in_ready;
   assign transfer = s1_valid && advance;

   // An operand produced by S1 is forwarded from the ALU output, so a dependent instruction can follow without a stall.
   always_comb begin
      rs_val = regfile[dec_rs];
      rt_val = regfile[dec_rt];
      if (s1_valid && dec_rs == s1_rd) rs_val = alu_res;
      if (s1_valid && dec_rt == s1_rd) rt_val = alu_res;
   end

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .sel    (s1_sel),
      .a      (s1_a),
      .b      (s1_b),
      .result (alu_res),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sel   <= '0;
         s1_rd    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_sel   <= dec_sel;
            s1_rd    <= dec_rd;
            s1_a     <= rs_val;
            s1_b     <= rt_val;
         end else if (advance) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_rd    <= '0;
         out_carry <= 1'b0;
         out_zero  <= 1'b1;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data  <= alu_res;
            out_rd    <= s1_rd;
            out_carry <= alu_carry;
            out_zero  <= (alu_res == '0);
         end
      end
   end

   // Writeback is assigned last, so it wins when it hits the same entry as a cfg write on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) regfile[i[AW-1:0]] <= '0;
      end else begin
         if (cfg_we)   regfile[cfg_addr] <= cfg_data;
         if (transfer) regfile[s1_rd]    <= alu_res;
      end
   end

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed testbench for decode_execute_pipe with WIDTH=4 and NREG=4.
// Every expected value is computed by hand.
module tb_decode_execute_pipe;

   localparam int WIDTH = 4;
   localparam int NREG  = 4;
   localparam int AW    = 2;
   localparam int IW    = 3 + 3 * AW;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [IW-1:0]    in_instr;
   logic             cfg_we;
   logic [AW-1:0]    cfg_addr;
   logic [WIDTH-1:0] cfg_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [AW-1:0]    out_rd;
   logic             out_carry;
   logic             out_zero;

   int n_checks = 0;
   int n_fail   = 0;

   decode_execute_pipe #(.WIDTH(WIDTH), .NREG(NREG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .out_carry (out_carry),
      .out_zero  (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [IW-1:0] enc(input logic [2:0] sel, input logic [1:0] rd,
                                         input logic [1:0] rs, input logic [1:0] rt);
      return {sel, rd, rs, rt};
   endfunction

   task automatic preload(input logic [1:0] addr, input logic [3:0] data);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = data;
      tick();
      cfg_we   = 1'b0;
   endtask

   // Issues one instruction into an idle pipe and checks its result two edges after acceptance.
   task automatic run_op(input string tag, input logic [2:0] sel, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [1:0] rt,
                         input logic [3:0] exp_d, input logic exp_c);
      in_valid = 1'b1;
      in_instr = enc(sel, rd, rs, rt);
      tick();
      in_valid = 1'b0;
      check({tag, " valid_k"}, out_valid, 0);
      tick();
      check({tag, " valid"}, out_valid, 1);
      check({tag, " data"},  out_data,  exp_d);
      check({tag, " carry"}, out_carry, exp_c);
      check({tag, " rd"},    out_rd,    rd);
      check({tag, " zero"},  out_zero,  exp_d == 4'h0);
      tick();
      check({tag, " drain"}, out_valid, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      out_ready = 1'b1;
      #12;
      check("rst in_ready",  in_ready,  1);
      check("rst out_valid", out_valid, 0);
      check("rst out_data",  out_data,  0);
      check("rst out_rd",    out_rd,    0);
      check("rst out_carry", out_carry, 0);
      check("rst out_zero",  out_zero,  1);
      rst_n = 1'b1;
      tick();

      preload(2'd1, 4'h2);
      preload(2'd2, 4'h7);
      run_op("add", 3'b001, 2'd3, 2'd1, 2'd2, 4'h9, 1'b0);
      run_op("sub1", 3'b000, 2'd0, 2'd1, 2'd2, 4'hB, 1'b0);
      run_op("sub2", 3'b000, 2'd0, 2'd2, 2'd1, 4'h5, 1'b1);

      // back-to-back dependency: AND r0 = r3 & r2 uses the ADD result through forwarding
      in_valid = 1'b1;
      in_instr = enc(3'b001, 2'd3, 2'd1, 2'd2);
      tick();
      check("b2b ready1", in_ready, 1);
      in_instr = enc(3'b011, 2'd0, 2'd3, 2'd2);
      tick();
      in_valid = 1'b0;
      check("b2b ready2", in_ready, 1);
      check("b2b d1", out_data, 4'h9);
      check("b2b rd1", out_rd, 2'd3);
      tick();
      check("b2b v2", out_valid, 1);
      check("b2b d2", out_data, 4'h1);
      check("b2b rd2", out_rd, 2'd0);
      tick();

      // backpressure: SUB r3 = r2 - r1 = 5, then OR r0 = r3 | r1 = 7 (forwarded)
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = enc(3'b000, 2'd3, 2'd2, 2'd1);
      tick();
      in_instr  = enc(3'b010, 2'd0, 2'd3, 2'd1);
      tick();
      in_valid  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp valid", out_valid, 1);
         check("bp data",  out_data,  4'h5);
         check("bp rd",    out_rd,    2'd3);
         check("bp ready", in_ready,  0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp ready rel", in_ready, 1);
      tick();
      check("bp v2",  out_valid, 1);
      check("bp d2",  out_data,  4'h7);
      check("bp rd2", out_rd,    2'd0);
      tick();
      check("bp drain", out_valid, 0);
      run_op("rf r3", 3'b010, 2'd3, 2'd3, 2'd3, 4'h5, 1'b0);
      run_op("rf r0", 3'b010, 2'd0, 2'd0, 2'd0, 4'h7, 1'b0);

      // op sweep with rs = rt = 9
      preload(2'd1, 4'h9);
      preload(2'd2, 4'h9);
      run_op("or",  3'b010, 2'd3, 2'd1, 2'd2, 4'h9, 1'b0);
      run_op("asr", 3'b100, 2'd3, 2'd1, 2'd2, 4'hC, 1'b0);
      run_op("rol", 3'b101, 2'd3, 2'd1, 2'd2, 4'h3, 1'b0);
      run_op("lt",  3'b110, 2'd3, 2'd1, 2'd2, 4'h0, 1'b0);
      run_op("eq",  3'b111, 2'd3, 2'd1, 2'd2, 4'h1, 1'b0);
      run_op("sub0", 3'b000, 2'd3, 2'd1, 2'd2, 4'h0, 1'b1);

      // reset asserted mid-stream with two instructions in flight
      in_valid = 1'b1;
      in_instr = enc(3'b001, 2'd3, 2'd1, 2'd2);
      tick();
      in_instr = enc(3'b001, 2'd0, 2'd1, 2'd2);
      tick();
      in_valid = 1'b0;
      check("mid valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst valid", out_valid, 0);
      check("arst data",  out_data,  0);
      check("arst zero",  out_zero,  1);
      #3;
      rst_n = 1'b1;
      tick();
      check("post ready", in_ready, 1);
      run_op("post add", 3'b001, 2'd3, 2'd1, 2'd2, 4'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_execute_pipe.md
# decode_execute_pipe

Parametrised two-stage decode-and-execute datapath: accepts encoded instructions over a valid/ready handshake, reads operands from an internal register file, executes one of eight ALU operations on WIDTH-bit data and writes the result back. Successor to the combinational 4-bit rs/rt/sel decode-and-execute block, adding pipelining, register storage, forwarding, flags and backpressure. Sits between the instruction sequencer and the result display/consumer.

## Interface
- WIDTH, 4, data width in bits (≥2)
- NREG, 4, register-file entries (power of two ≥2); AW = $clog2(NREG)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  block can accept instruction this cycle
- in_instr  in  3+3*AW  {sel[2:0], rd_addr, rs_addr, rt_addr}
- cfg_we  in  1  register-file preload write enable
- cfg_addr  in  AW  preload address
- cfg_data  in  WIDTH  preload data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_rd  out  AW  destination register of result
- out_carry  out  1  carry (ADD) / no-borrow (SUB); 0 otherwise
- out_zero  out  1  out_data == 0

## Operation
- sel: 000 SUB rs−rt; 001 ADD rs+rt; 010 OR; 011 AND; 100 rt arithmetic shift right by 1; 101 rs rotate left by 1; 110 LT unsigned (rs<rt → 1, else 0, zero-extended); 111 EQ (rs==rt → 1, else 0).
- Arithmetic computed on WIDTH+1 bits; out_data = low WIDTH bits; out_carry = bit WIDTH (SUB: rs + ~rt + 1).
- S1 (decode): on in_valid && in_ready, latch sel, rd_addr, rs and rt operands.
- Operand read: regfile value, bypassed by S1's own result when S1 valid and rs_addr/rt_addr == S1.rd_addr (back-to-back dependency needs no stall).
- S2 (execute): on S1 → S2 transfer, register ALU result/flags into out_*, and write result to regfile[rd_addr] on the same edge.
- cfg write happens when cfg_we; same-edge same-address collision with writeback: writeback wins. cfg write is not forwarded into S1.

## Timing
- Reset: all regfile entries 0; S1/S2 valid 0; out_data/out_rd/out_carry 0; out_zero 1; out_valid 0.
- in_ready = !S1.valid || advance, where advance = !out_valid || out_ready (combinational; in_ready 1 out of reset).
- Latency: instruction accepted at edge k → out_valid high after edge k+1; throughput one per cycle with out_ready held high.
- out_valid && !out_ready: out_* hold stable, S1 holds, in_ready low if S1 occupied; no writeback.
- S2 drains without new S1 data: out_valid falls after the accepting edge.
- Reset asserted mid-operation: in-flight instructions discarded, outputs to reset values immediately (asynchronous).

## Structure
- Shared package decode_execute_pkg: sel opcode localparams (OP_SUB … OP_EQ) and instruction field offsets as functions of AW.
- One sub-module: alu_core (combinational, WIDTH-parametrised; sel, a, b → result, carry).
- Top holds regfile, S1/S2 registers, forwarding muxes, handshake logic.

## Test plan (WIDTH=4, NREG=4)
- Preload r1=2, r2=7; issue ADD r3=r1+r2 → out_data 9, out_carry 0, out_rd 3, out_valid two edges after accept.
- Preload r1=2, r2=7; SUB r0=r1−r2 → out_data 0xB, out_carry 0; then SUB r0=r2−r1 → 5, carry 1.
- Back-to-back ADD r3=r1+r2 (9), then AND r0=r3&r2 → 1 (forwarded, no bubble, in_ready stays 1).
- out_ready low for 3 cycles with two instructions issued → out_* stable, in_ready low, second result delivered after out_ready high; final regfile matches both results.
- Op sweep rs=0x9, rt=0x9: OR 9, rt>>>1 0xC, rotl 0x3, LT 0, EQ 1, SUB 0 with out_zero 1.
- Assert rst_n mid-stream → out_valid 0 immediately, regfile reads 0 afterwards, in_ready 1 after release.
